// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared types and constants for the multi-port register file
//
// Purpose: FSM state type, the hard-wired zero register index and the default
//          data width / register count shared with decode and writeback.
// Ports:   none (package).

package regfile_pkg;

   typedef enum logic {
      CLEAR = 1'b0,
      RUN   = 1'b1
   } state_t;

   localparam int REG_ZERO      = 0;
   localparam int DEFAULT_XLEN  = 32;
   localparam int DEFAULT_NREGS = 32;

endpackage

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register pending bits with NRD lookup ports
//
// Purpose: one pending bit per architectural register. Issue sets a bit,
//          writeback clears it; when both hit the same register in the same
//          cycle the set wins because the newly issued producer is still in
//          flight. Register 0 is never pending.
// Ports:
//   clk     in   core clock
//   reset   in   synchronous active-low reset, clears every bit
//   run     in   updates are accepted only while 1
//   set_en  in   issue strobe (caller already excludes register 0)
//   set_rd  in   register being issued
//   clr_en  in   writeback strobe
//   clr_rd  in   register being written back
//   rs      in   NRD lookup addresses, port k at [k*AW +: AW]
//   busy    out  pending bit per lookup port, 0 for register 0

module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREGS = DEFAULT_NREGS,
   parameter int NRD   = 2,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic              set_en,
   input  logic [AW-1:0]     set_rd,
   input  logic              clr_en,
   input  logic [AW-1:0]     clr_rd,
   input  logic [NRD*AW-1:0] rs,
   output logic [NRD-1:0]    busy
);

   logic [NREGS-1:0] pend;
   logic [NREGS-1:0] pend_next;

   // Clear is applied before set so that a same-register collision leaves
   // the bit set.
   always_comb begin
      pend_next = pend;
      if (run) begin
         if (clr_en) pend_next[clr_rd] = 1'b0;
         if (set_en) pend_next[set_rd] = 1'b1;
      end
      pend_next[REG_ZERO] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!reset) pend <= '0;
      else        pend <= pend_next;
   end

   always_comb begin
      busy = '0;
      for (int k = 0; k < NRD; k++) begin
         busy[k] = pend[rs[k*AW +: AW]] && (rs[k*AW +: AW] != AW'(REG_ZERO));
      end
   end

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port integer register file with scoreboard
//
// Purpose: NREGS x XLEN register file, one write port, NRD combinational read
//          ports, and a pending-bit scoreboard. After reset a sweep FSM clears
//          one entry per cycle; ready rises once every entry is zero.
// Build option: REGFILE_BYPASS_EN forwards the writeback data to any read port
//          addressing the register being written in the same cycle.
// Ports:
//   clk       in   core clock
//   reset     in   synchronous active-low reset
//   ready     out  1 once the clear sweep has finished
//   RegWrite  in   writeback write enable
//   RdW       in   writeback destination register
//   WD        in   writeback data
//   Rs        in   read addresses, port k at [k*AW +: AW]
//   RD        out  read data, port k at [k*XLEN +: XLEN]
//   RsBusy    out  pending flag per read port
//   IssueEn   in   decode issues an instruction writing IssueRd
//   IssueRd   in   destination register being issued

module regfile_mp
   import regfile_pkg::*;
#(
   parameter int XLEN  = DEFAULT_XLEN,
   parameter int NREGS = DEFAULT_NREGS,
   parameter int NRD   = 2,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                reset,
   output logic                ready,
   input  logic                RegWrite,
   input  logic [AW-1:0]       RdW,
   input  logic [XLEN-1:0]     WD,
   input  logic [NRD*AW-1:0]   Rs,
   output logic [NRD*XLEN-1:0] RD,
   output logic [NRD-1:0]      RsBusy,
   input  logic                IssueEn,
   input  logic [AW-1:0]       IssueRd
);

   localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

   state_t          state, state_next;
   logic [AW-1:0]   ptr, ptr_next;
   logic            ready_next;
   logic            run;
   logic            wr_ok;
   logic            issue_ok;
   logic [NRD-1:0]  sb_busy;
   logic [XLEN-1:0] mem [NREGS];

   assign run      = (state == RUN);
   assign wr_ok    = RegWrite && run && (RdW != AW'(REG_ZERO));
   assign issue_ok = IssueEn && run && (IssueRd != AW'(REG_ZERO));

   always_ff @(posedge clk) begin
      if (!reset) begin
         state <= CLEAR;
         ptr   <= '0;
         ready <= 1'b0;
      end else begin
         state <= state_next;
         ptr   <= ptr_next;
         ready <= ready_next;
      end
   end

   always_comb begin
      state_next = state;
      ptr_next   = ptr;
      ready_next = ready;
      case (state)
         CLEAR: begin
            ptr_next = ptr + 1'b1;
            if (ptr == LAST) begin
               state_next = RUN;
               ready_next = 1'b1;
            end
         end
         RUN: ;
         default: state_next = CLEAR;
      endcase
   end

   // The sweep owns the write port until it finishes; no write happens on a
   // reset edge, so the sweep always starts afresh from entry 0.
   always_ff @(posedge clk) begin
      if (reset) begin
         if (!run)       mem[ptr] <= '0;
         else if (wr_ok) mem[RdW] <= WD;
      end
   end

   regfile_scoreboard #(
      .NREGS (NREGS),
      .NRD   (NRD)
   ) u_scoreboard (
      .clk    (clk),
      .reset  (reset),
      .run    (run),
      .set_en (issue_ok),
      .set_rd (IssueRd),
      .clr_en (RegWrite && run),
      .clr_rd (RdW),
      .rs     (Rs),
      .busy   (sb_busy)
   );

   always_comb begin
      RD     = '0;
      RsBusy = '0;
      for (int k = 0; k < NRD; k++) begin
         if (run && (Rs[k*AW +: AW] != AW'(REG_ZERO))) begin
            RD[k*XLEN +: XLEN] = mem[Rs[k*AW +: AW]];
            RsBusy[k]          = sb_busy[k];
`ifdef REGFILE_BYPASS_EN
            // The forwarded value is already available, so the port is only
            // busy if a newer producer is being issued this very cycle.
            if (wr_ok && (Rs[k*AW +: AW] == RdW)) begin
               RD[k*XLEN +: XLEN] = WD;
               RsBusy[k]          = issue_ok && (IssueRd == RdW);
            end
`endif
         end
      end
   end

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - self-checking bench for regfile_mp (NRD=3)

module tb_regfile_mp;

   localparam int XLEN  = 32;
   localparam int NREGS = 32;
   localparam int NRD   = 3;
   localparam int AW    = 5;

   logic                clk = 1'b0;
   logic                reset;
   logic                ready;
   logic                RegWrite;
   logic [AW-1:0]       RdW;
   logic [XLEN-1:0]     WD;
   logic [NRD*AW-1:0]   Rs;
   logic [NRD*XLEN-1:0] RD;
   logic [NRD-1:0]      RsBusy;
   logic                IssueEn;
   logic [AW-1:0]       IssueRd;

   always #5 clk = ~clk;

   regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
      .clk      (clk),
      .reset    (reset),
      .ready    (ready),
      .RegWrite (RegWrite),
      .RdW      (RdW),
      .WD       (WD),
      .Rs       (Rs),
      .RD       (RD),
      .RsBusy   (RsBusy),
      .IssueEn  (IssueEn),
      .IssueRd  (IssueRd)
   );

   int vectors     = 0;
   int miscompares = 0;

   // Reference model: register contents, pending set, and cycles of sweep left.
   logic [XLEN-1:0] m_regs [NREGS];
   bit              m_pend [NREGS];
   bit              m_run;
   int              m_left;

   typedef struct {
      logic        we;
      logic [4:0]  rdw;
      logic [31:0] wd;
      logic        ie;
      logic [4:0]  ird;
      logic [14:0] rs;
      logic [95:0] exp_rd;
      logic [2:0]  exp_busy;
   } vec_t;

   vec_t tab [13];

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_expect(input logic [14:0] rs, input logic we, input logic [4:0] rdw,
                               input logic [31:0] wd, input logic ie, input logic [4:0] ird,
                               output logic [95:0] e_rd, output logic [2:0] e_busy);
      int a;
      e_rd   = '0;
      e_busy = '0;
      for (int k = 0; k < NRD; k++) begin
         a = int'(rs[k*AW +: AW]);
         if (m_run && a != 0) begin
            e_rd[k*XLEN +: XLEN] = m_regs[a];
            e_busy[k]            = m_pend[a];
`ifdef REGFILE_BYPASS_EN
            if (we && int'(rdw) == a) begin
               e_rd[k*XLEN +: XLEN] = wd;
               e_busy[k]            = ie && int'(ird) == a;
            end
`endif
         end
      end
   endtask

   task automatic model_edge(input logic rst, input logic we, input logic [4:0] rdw,
                             input logic [31:0] wd, input logic ie, input logic [4:0] ird);
      if (!rst) begin
         m_run  = 1'b0;
         m_left = NREGS;
         for (int i = 0; i < NREGS; i++) begin
            m_regs[i] = '0;
            m_pend[i] = 1'b0;
         end
      end else if (!m_run) begin
         m_left--;
         if (m_left == 0) m_run = 1'b1;
      end else begin
         if (we) m_pend[rdw] = 1'b0;
         if (ie && ird != 0) m_pend[ird] = 1'b1;
         if (we && rdw != 0) m_regs[rdw] = wd;
      end
   endtask

   task automatic cycle(input logic rst, input logic we, input logic [4:0] rdw,
                        input logic [31:0] wd, input logic ie, input logic [4:0] ird,
                        input logic [14:0] rs, input bit use_tab,
                        input logic [95:0] t_rd, input logic [2:0] t_busy);
      logic [95:0] e_rd;
      logic [2:0]  e_busy;
      @(negedge clk);
      reset = rst; RegWrite = we; RdW = rdw; WD = wd;
      IssueEn = ie; IssueRd = ird; Rs = rs;
      #2;
      model_expect(rs, we, rdw, wd, ie, ird, e_rd, e_busy);
      if (use_tab) begin
         e_rd   = t_rd;
         e_busy = t_busy;
      end
      check("RD", RD, e_rd);
      check("RsBusy", 96'(RsBusy), 96'(e_busy));
      check("ready", 96'(ready), 96'(m_run));
      @(posedge clk);
      model_edge(rst, we, rdw, wd, ie, ird);
   endtask

   task automatic idle(input logic rst);
      cycle(rst, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 15'd0, 1'b0, 96'd0, 3'd0);
   endtask

   // Runs cycles with reset released until ready is seen; returns edge count.
   task automatic sweep(output int edges);
      edges = 0;
      while (ready !== 1'b1 && edges < 100) begin
         if (edges == 15)
            cycle(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 5'd5, {5'd5, 5'd5, 5'd5}, 1'b0, 96'd0, 3'd0);
         else
            idle(1'b1);
         edges++;
         #1;
      end
   endtask

   logic [31:0] byp_exp;
   int          edges;

   initial begin
      tab[0]  = '{1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, {5'd0,5'd0,5'd0}, 96'd0, 3'b000};
      tab[1]  = '{1'b1, 5'd6, 32'hCAFEF00D, 1'b0, 5'd0, {5'd0,5'd0,5'd0}, 96'd0, 3'b000};
      tab[2]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, {5'd5,5'd6,5'd5},
                  {32'h12345678, 32'hCAFEF00D, 32'h12345678}, 3'b000};
      tab[3]  = '{1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, {5'd0,5'd0,5'd0}, 96'd0, 3'b000};
      tab[4]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, {5'd6,5'd5,5'd0},
                  {32'hCAFEF00D, 32'h12345678, 32'h0}, 3'b000};
      tab[5]  = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, {5'd0,5'd0,5'd0}, 96'd0, 3'b000};
      tab[6]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, {5'd0,5'd0,5'd7}, 96'd0, 3'b001};
      tab[7]  = '{1'b1, 5'd7, 32'h11111111, 1'b0, 5'd0, {5'd0,5'd0,5'd0}, 96'd0, 3'b000};
      tab[8]  = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, {5'd0,5'd0,5'd7},
                  {32'h0, 32'h0, 32'h11111111}, 3'b000};
      tab[9]  = '{1'b1, 5'd7, 32'h22222222, 1'b1, 5'd7, {5'd0,5'd0,5'd0}, 96'd0, 3'b000};
      tab[10] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, {5'd7,5'd7,5'd7},
                  {32'h22222222, 32'h22222222, 32'h22222222}, 3'b111};
      tab[11] = '{1'b1, 5'd7, 32'h33333333, 1'b0, 5'd0, {5'd5,5'd0,5'd0},
                  {32'h12345678, 32'h0, 32'h0}, 3'b000};
      tab[12] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, {5'd7,5'd5,5'd7},
                  {32'h33333333, 32'h12345678, 32'h33333333}, 3'b000};

      reset = 1'b0; RegWrite = 1'b0; RdW = '0; WD = '0;
      IssueEn = 1'b0; IssueRd = '0; Rs = '0;
      m_run = 1'b0; m_left = NREGS;
      for (int i = 0; i < NREGS; i++) begin m_regs[i] = '0; m_pend[i] = 1'b0; end
      @(posedge clk);

      // Reset held, then the sweep with a write attempt part-way through.
      for (int i = 0; i < 3; i++) idle(1'b0);
      sweep(edges);
      check("sweep_cycles", 96'(edges), 96'd32);

      for (int i = 0; i < 13; i++)
         cycle(1'b1, tab[i].we, tab[i].rdw, tab[i].wd, tab[i].ie, tab[i].ird, tab[i].rs,
               1'b1, tab[i].exp_rd, tab[i].exp_busy);

      // Same-cycle read of the register being written.
`ifdef REGFILE_BYPASS_EN
      byp_exp = 32'hA5A5A5A5;
`else
      byp_exp = 32'h0;
`endif
      cycle(1'b1, 1'b1, 5'd9, 32'hA5A5A5A5, 1'b0, 5'd0, {5'd0,5'd0,5'd9}, 1'b1,
            {64'd0, byp_exp}, 3'b000);
      cycle(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, {5'd0,5'd0,5'd9}, 1'b1,
            {64'd0, 32'hA5A5A5A5}, 3'b000);

      // Random traffic on a small register window to force collisions.
      for (int i = 0; i < 400; i++)
         cycle(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
               {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))},
               1'b0, 96'd0, 3'd0);

      // Leave r3/r4 pending, reset, interrupt the sweep at ptr=10, restart.
      cycle(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 15'd0, 1'b0, 96'd0, 3'd0);
      cycle(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 15'd0, 1'b0, 96'd0, 3'd0);
      for (int i = 0; i < 2; i++) idle(1'b0);
      for (int i = 0; i < 10; i++) idle(1'b1);
      for (int i = 0; i < 2; i++)
         cycle(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 15'd0, 1'b0, 96'd0, 3'd0);
      sweep(edges);
      check("restart_sweep_cycles", 96'(edges), 96'd32);
      cycle(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, {5'd4,5'd3,5'd5}, 1'b1, 96'd0, 3'b000);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
